sign_extend: RTL and testbench
==============================

// Module: sign_extend
// PURPOSE
//  Immediate-extension unit for the MIPS datapath. Widens a 16-bit instruction
//  immediate to a 32-bit operand for the ALU, branch and LUI paths.
//  Primary output out32 is purely combinational; with ext_op=0 it is a plain
//  16->32 sign extension. A registered copy with valid feeds the next stage.
// PARAMETERS
//  IN_W    16  immediate input width (fixed at 16; other values unsupported)
//  OUT_W   32  extended output width (fixed at 32)
// PORTS
//  clk        in   1   clock, rising edge; only the pipeline register uses it
//  reset_n    in   1   synchronous, active-low reset
//  in16       in   16  immediate from the instruction word
//  ext_op     in   3   extension mode (encoding below)
//  en         in   1   load enable for the output register
//  out32      out  32  combinational extended value
//  is_neg     out  1   combinational, = out32[31]
//  is_zero    out  1   combinational, = (out32 == 0)
//  out32_q    out  32  registered out32
//  valid_q    out  1   registered: high when out32_q holds a loaded value
// BEHAVIOUR
//  - out32, is_neg and is_zero depend only on in16 and ext_op.
//    - They have zero-cycle latency and no clock dependency.
//    - They settle within the same delta or time step as an input change.
//  - ext_op encoding:
//    - 000 sext16: {{16{in16[15]}}, in16}. This is the default mode.
//    - 001 zext16: {16'b0, in16}
//    - 010 lui: {in16, 16'b0}
//    - 011 branch offset: sext16 result << 2. Bits [31:18] are copies of in16[15].
//    - 100 sext8: {{24{in16[7]}}, in16[7:0]}. in16[15:8] is ignored.
//    - 101 zext8: {24'b0, in16[7:0]}
//    - 110, 111 reserved: behave exactly as 000 (sext16).
//  - Register stage, evaluated on the rising edge of clk:
//    - reset_n=0: out32_q <= 0 and valid_q <= 0. Reset overrides en.
//    - reset_n=1, en=1: out32_q <= out32 and valid_q <= 1. Latency is 1 cycle.
//    - reset_n=1, en=0: out32_q holds its value and valid_q <= 0.
//  - reset_n has no effect on the combinational outputs.
//  - Asserting reset in the middle of a stream clears valid_q on the next edge.
//  - No X propagation from reserved ext_op codes.
//  - No latches; every combinational path is fully assigned.
// TESTING
//  1. ext_op=000, in16=16'h0000 -> out32=32'h00000000, is_zero=1, is_neg=0
//     - Checked 1 time unit after the input changes, with no clock edge.
//  2. ext_op=000, in16=16'hFFFF -> out32=32'hFFFFFFFF, is_neg=1
//     Also: in16=16'h7FFF -> 32'h00007FFF and 16'h8000 -> 32'hFFFF8000.
//  3. Other modes with in16=16'h8001:
//     - zext16 -> 32'h00008001
//     - lui -> 32'h80010000
//     - branch -> 32'hFFFE0004
//     - sext8 (in16=16'h1280) -> 32'hFFFFFF80
//     - zext8 (in16=16'h1280) -> 32'h00000080
//     - ext_op=111 with in16=16'hFFFF -> 32'hFFFFFFFF
//  4. Register stage:
//     - Hold reset_n=0 for 2 edges -> out32_q=0, valid_q=0.
//     - Release reset; en=1, in16=16'hFFFF, ext_op=000 -> after 1 edge
//       out32_q=32'hFFFFFFFF and valid_q=1.
//     - en=0 -> out32_q holds 32'hFFFFFFFF and valid_q=0.
//  5. Reset priority: assert reset_n=0 together with en=1 -> next edge gives
//     out32_q=0 and valid_q=0. out32 still follows in16 during reset.
//  6. Exhaustive sweep: all 65536 in16 values x 8 ext_op codes vs a reference
//     model, checking out32, is_neg and is_zero.

Source files
------------

// File: rtl/sign_extend.sv
// Immediate-extension unit: widens a 16-bit instruction immediate to a 32-bit
// operand combinationally, with an optional registered copy for the next stage.
module sign_extend #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [IN_W-1:0]  in16,
   input  logic [2:0]       ext_op,
   input  logic             en,
   output logic [OUT_W-1:0] out32,
   output logic             is_neg,
   output logic             is_zero,
   output logic [OUT_W-1:0] out32_q,
   output logic             valid_q
);

   typedef enum logic [2:0] {
      OP_SEXT16 = 3'b000,
      OP_ZEXT16 = 3'b001,
      OP_LUI    = 3'b010,
      OP_BRANCH = 3'b011,
      OP_SEXT8  = 3'b100,
      OP_ZEXT8  = 3'b101
   } ext_op_t;

   localparam int HI_W   = OUT_W - IN_W;
   localparam int BYTE_W = 8;

   logic [OUT_W-1:0] sext16;
   logic [OUT_W-1:0] zext16;
   logic [OUT_W-1:0] lui_val;
   logic [OUT_W-1:0] branch_val;
   logic [OUT_W-1:0] sext8;
   logic [OUT_W-1:0] zext8;
   logic [OUT_W-1:0] out_next;

   assign sext16     = {{HI_W{in16[IN_W-1]}}, in16};
   assign zext16     = {{HI_W{1'b0}}, in16};
   assign lui_val    = {in16, {HI_W{1'b0}}};
   assign branch_val = {sext16[OUT_W-3:0], 2'b00};
   assign sext8      = {{(OUT_W-BYTE_W){in16[BYTE_W-1]}}, in16[BYTE_W-1:0]};
   assign zext8      = {{(OUT_W-BYTE_W){1'b0}}, in16[BYTE_W-1:0]};

   // Reserved codes fall through to sext16 so no X ever reaches the output.
   always_comb begin
      out_next = sext16;
      case (ext_op)
         OP_ZEXT16: out_next = zext16;
         OP_LUI:    out_next = lui_val;
         OP_BRANCH: out_next = branch_val;
         OP_SEXT8:  out_next = sext8;
         OP_ZEXT8:  out_next = zext8;
         default:   out_next = sext16;
      endcase
   end

   assign out32   = out_next;
   assign is_neg  = out_next[OUT_W-1];
   assign is_zero = (out_next == '0);

   // Reset outranks en; valid_q only flags the cycle right after a load.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out32_q <= '0;
         valid_q <= 1'b0;
      end else if (en) begin
         out32_q <= out_next;
         valid_q <= 1'b1;
      end else begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sign_extend.sv
// Directed-vector and exhaustive check of sign_extend, plus the register
// stage sequences for load, hold and reset priority.
module tb_sign_extend;

   logic        clk;
   logic        reset_n;
   logic [15:0] in16;
   logic [2:0]  ext_op;
   logic        en;
   logic [31:0] out32;
   logic        is_neg;
   logic        is_zero;
   logic [31:0] out32_q;
   logic        valid_q;

   int total = 0;
   int bad   = 0;

   sign_extend dut (
      .clk     (clk),
      .reset_n (reset_n),
      .in16    (in16),
      .ext_op  (ext_op),
      .en      (en),
      .out32   (out32),
      .is_neg  (is_neg),
      .is_zero (is_zero),
      .out32_q (out32_q),
      .valid_q (valid_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] in16;
      logic [2:0]  op;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [15:0] v, input logic [2:0] op);
      int s16;
      int s8;
      s16 = int'($signed(v));
      s8  = int'($signed(v[7:0]));
      case (op)
         3'd1:    return 32'(v);
         3'd2:    return 32'(v) * 32'd65536;
         3'd3:    return 32'(s16 * 4);
         3'd4:    return 32'(s8);
         3'd5:    return 32'(v) & 32'h0000_00FF;
         default: return 32'(s16);
      endcase
   endfunction

   initial begin
      logic [31:0] e;
      reset_n = 1'b1;
      en      = 1'b0;
      in16    = '0;
      ext_op  = '0;

      vecs[0]  = '{16'h0000, 3'b000, 32'h0000_0000};
      vecs[1]  = '{16'hFFFF, 3'b000, 32'hFFFF_FFFF};
      vecs[2]  = '{16'h7FFF, 3'b000, 32'h0000_7FFF};
      vecs[3]  = '{16'h8000, 3'b000, 32'hFFFF_8000};
      vecs[4]  = '{16'h8001, 3'b001, 32'h0000_8001};
      vecs[5]  = '{16'h8001, 3'b010, 32'h8001_0000};
      vecs[6]  = '{16'h8001, 3'b011, 32'hFFFE_0004};
      vecs[7]  = '{16'h1280, 3'b100, 32'hFFFF_FF80};
      vecs[8]  = '{16'h1280, 3'b101, 32'h0000_0080};
      vecs[9]  = '{16'hFFFF, 3'b111, 32'hFFFF_FFFF};
      vecs[10] = '{16'h0001, 3'b110, 32'h0000_0001};

      // Combinational vectors, sampled 1 time unit after each change.
      for (int i = 0; i < 11; i++) begin
         in16   = vecs[i].in16;
         ext_op = vecs[i].op;
         #1;
         check($sformatf("vec%0d out32", i), out32, vecs[i].exp);
         check($sformatf("vec%0d is_neg", i), {31'b0, is_neg}, {31'b0, vecs[i].exp[31]});
         check($sformatf("vec%0d is_zero", i), {31'b0, is_zero}, {31'b0, vecs[i].exp == 32'h0});
         $display("vec%0d in16=%h op=%0d out32=%h neg=%0b zero=%0b", i, in16, ext_op, out32, is_neg, is_zero);
      end

      // Reset for two edges.
      @(negedge clk);
      reset_n = 1'b0;
      en      = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset out32_q", out32_q, 32'h0);
      check("reset valid_q", {31'b0, valid_q}, 32'h0);
      $display("reset out32_q=%h valid_q=%0b", out32_q, valid_q);

      // Load.
      @(negedge clk);
      reset_n = 1'b1;
      en      = 1'b1;
      in16    = 16'hFFFF;
      ext_op  = 3'b000;
      @(posedge clk);
      #1;
      check("load out32_q", out32_q, 32'hFFFF_FFFF);
      check("load valid_q", {31'b0, valid_q}, 32'h1);
      $display("load out32_q=%h valid_q=%0b", out32_q, valid_q);

      // Hold with en=0 while input changes.
      @(negedge clk);
      en   = 1'b0;
      in16 = 16'h1234;
      @(posedge clk);
      #1;
      check("hold out32_q", out32_q, 32'hFFFF_FFFF);
      check("hold valid_q", {31'b0, valid_q}, 32'h0);
      $display("hold out32_q=%h valid_q=%0b", out32_q, valid_q);

      // Second load in lui mode.
      @(negedge clk);
      en     = 1'b1;
      ext_op = 3'b010;
      @(posedge clk);
      #1;
      check("load2 out32_q", out32_q, 32'h1234_0000);
      check("load2 valid_q", {31'b0, valid_q}, 32'h1);
      $display("load2 out32_q=%h valid_q=%0b", out32_q, valid_q);

      // Reset asserted together with en mid-stream.
      @(negedge clk);
      reset_n = 1'b0;
      en      = 1'b1;
      in16    = 16'h8000;
      ext_op  = 3'b000;
      #1;
      check("reset comb out32", out32, 32'hFFFF_8000);
      @(posedge clk);
      #1;
      check("rstprio out32_q", out32_q, 32'h0);
      check("rstprio valid_q", {31'b0, valid_q}, 32'h0);
      $display("rstprio out32_q=%h valid_q=%0b out32=%h", out32_q, valid_q, out32);

      // Exhaustive sweep against the reference model.
      reset_n = 1'b1;
      en      = 1'b0;
      for (int op = 0; op < 8; op++) begin
         int errs_before;
         errs_before = bad;
         for (int v = 0; v < 65536; v++) begin
            in16   = 16'(v);
            ext_op = 3'(op);
            #1;
            e = ref_model(in16, ext_op);
            check($sformatf("sweep op%0d in%h out32", op, in16), out32, e);
            check($sformatf("sweep op%0d in%h is_neg", op, in16), {31'b0, is_neg}, {31'b0, e[31]});
            check($sformatf("sweep op%0d in%h is_zero", op, in16), {31'b0, is_zero}, {31'b0, e == 32'h0});
         end
         $display("sweep op=%0d errors=%0d", op, bad - errs_before);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
